alu_div_unit: RTL and testbench

//  Multicycle iterative divider that serves division/modulo requests issued by the CPU datapath.

---
 rtl/alu_pkg.sv | 10 +
 rtl/div_step.sv | 25 ++
 rtl/alu_div_unit.sv | 120 ++++++++++++
 tb/tb_alu_div_unit.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider FSM states, datapath width and opcode encodings.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;

  typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_MOD} alu_op_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration on a {rem,quo} register pair.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;

  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    quo_next = {quo[WIDTH-2:0], 1'b0};
    rem_next = shifted[WIDTH-1:0];
    if (shifted >= {1'b0, divisor}) begin
      // difference is below divisor, so it always fits in WIDTH bits
      rem_next    = shifted[WIDTH-1:0] - divisor;
      quo_next[0] = 1'b1;
    end
  end

endmodule

// File: rtl/alu_div_unit.sv
// Multicycle restoring divider with valid/ready request and response channels.
// Optional two's-complement mode is enabled by defining ALU_DIV_SIGNED_EN.
module alu_div_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef ALU_DIV_SIGNED_EN
  input  logic             is_signed,
`endif
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  div_state_t       state, state_n;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem, quo, dvs;
  logic [WIDTH-1:0] rem_n, quo_n;
  logic [WIDTH-1:0] dend_mag, dvs_mag;
  logic             sgn, neg_q, neg_r;

`ifdef ALU_DIV_SIGNED_EN
  assign sgn = is_signed;
`else
  assign sgn = 1'b0;
`endif

  assign dend_mag = (sgn && dividend[WIDTH-1]) ? -dividend : dividend;
  assign dvs_mag  = (sgn && divisor[WIDTH-1])  ? -divisor  : divisor;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .quo      (quo),
    .divisor  (dvs),
    .rem_next (rem_n),
    .quo_next (quo_n)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_n = (divisor == '0) ? DONE : CALC;
      end
      CALC: begin
        if (cnt == '0) state_n = DONE;
      end
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      rem         <= '0;
      quo         <= '0;
      dvs         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            rem   <= '0;
            quo   <= dend_mag;
            dvs   <= dvs_mag;
            cnt   <= CW'(WIDTH - 1);
            neg_q <= sgn && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r <= sgn && dividend[WIDTH-1];
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end
          end
        end
        CALC: begin
          rem <= rem_n;
          quo <= quo_n;
          if (cnt == '0) begin
            // last step feeds the result registers directly so the sign fix-up costs no cycle
            quotient    <= neg_q ? -quo_n : quo_n;
            remainder   <= neg_r ? -rem_n : rem_n;
            div_by_zero <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_div_unit.sv
// Randomized self-checking bench for alu_div_unit against a plain-arithmetic reference model.
module tb_alu_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         is_signed;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_tests = 0;
  int n_fail  = 0;

  alu_div_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .dividend    (dividend),
    .divisor     (divisor),
`ifdef ALU_DIV_SIGNED_EN
    .is_signed   (is_signed),
`endif
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // C-style truncating division; 64-bit arithmetic sidesteps MIN/-1 overflow.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                                output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    longint sa, sb;
    z = (b == 0);
    if (b == 0) begin
      q = '1;
      r = a;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = W'(sa / sb);
      r  = W'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                        input int hold, input bit early);
    logic [W-1:0] eq, er;
    logic         ez;
    int           lat;
    model(a, b, s, eq, er, ez);
    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    dividend  = a;
    divisor   = b;
    is_signed = s;
    rsp_ready = early;
    @(posedge clk); #1;
    req_valid = 1'b0;
    dividend  = $urandom;
    divisor   = $urandom;
    is_signed = 1'($urandom_range(0, 1));
    lat = 1;
    while (!rsp_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, (b == 0) ? 1 : W + 1);
    check("quotient", quotient, eq);
    check("remainder", remainder, er);
    check("div_by_zero", div_by_zero, ez);
    check("req_ready_done", req_ready, 0);
    if (!early) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        check("hold_valid", rsp_valid, 1);
        check("hold_quotient", quotient, eq);
        check("hold_remainder", remainder, er);
        check("hold_req_ready", req_ready, 0);
      end
      rsp_ready = 1'b1;
    end
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("post_rsp_valid", rsp_valid, 0);
    check("post_req_ready", req_ready, 1);
  endtask

  initial begin
    logic [W-1:0] a, b;
    bit           s;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    dividend  = '0;
    divisor   = '0;
    is_signed = 1'b0;
    rsp_ready = 1'b0;
    #3;
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_dbz", div_by_zero, 0);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    do_div(32'd100, 32'd7, 1'b0, 0, 1'b1);
    do_div(32'hFFFF_FFFF, 32'd1, 1'b0, 0, 1'b1);
    do_div(32'd5, 32'd9, 1'b0, 0, 1'b1);
    do_div(32'd123, 32'd0, 1'b0, 0, 1'b1);
    do_div(32'd77, 32'd4, 1'b0, 10, 1'b0);
    do_div(32'd9, 32'd0, 1'b0, 10, 1'b0);

    // reset in the middle of a computation
    req_valid = 1'b1;
    dividend  = 32'd1000;
    divisor   = 32'd3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1 rst_n = 1'b0;
    #2;
    check("midrst_req_ready", req_ready, 1);
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_quotient", quotient, 0);
    check("midrst_remainder", remainder, 0);
    check("midrst_dbz", div_by_zero, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_div(32'd50, 32'd5, 1'b0, 0, 1'b1);

`ifdef ALU_DIV_SIGNED_EN
    do_div(-32'sd7, 32'd2, 1'b1, 0, 1'b1);
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0, 1'b1);
    do_div(32'd7, -32'sd2, 1'b1, 2, 1'b0);
    do_div(-32'sd5, 32'd0, 1'b1, 0, 1'b1);
`endif

    for (int n = 0; n < 40; n++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 15));
        2:       b = $urandom;
        default: begin a = W'($urandom_range(0, 1000)); b = a + W'($urandom_range(1, 1000)); end
      endcase
`ifdef ALU_DIV_SIGNED_EN
      s = 1'($urandom_range(0, 1));
`else
      s = 1'b0;
`endif
      do_div(a, b, s, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
